// File: rtl/tiny_dnn_pkg.sv
// Shared types for the layer sequencer: descriptor layout, FSM states and
// the beat-count helper used by the weight phase.
package tiny_dnn_pkg;

  localparam int unsigned MAX_LAYERS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NB_W       = 8;
  localparam int unsigned BEAT_W     = 13;

  localparam int unsigned SS_W = 12;
  localparam int unsigned ID_W = 4;
  localparam int unsigned IS_W = 10;
  localparam int unsigned IH_W = 5;
  localparam int unsigned IW_W = 5;
  localparam int unsigned DS_W = 12;
  localparam int unsigned OD_W = 4;
  localparam int unsigned OS_W = 10;
  localparam int unsigned OH_W = 5;
  localparam int unsigned OW_W = 5;
  localparam int unsigned FS_W = 8;
  localparam int unsigned KH_W = 3;
  localparam int unsigned KW_W = 3;

  typedef struct packed {
    logic [SS_W-1:0] ss;
    logic [ID_W-1:0] id;
    logic [IS_W-1:0] is;
    logic [IH_W-1:0] ih;
    logic [IW_W-1:0] iw;
    logic [DS_W-1:0] ds;
    logic [OD_W-1:0] od;
    logic [OS_W-1:0] os;
    logic [OH_W-1:0] oh;
    logic [OW_W-1:0] ow;
    logic [FS_W-1:0] fs;
    logic [KH_W-1:0] kh;
    logic [KW_W-1:0] kw;
  } layer_cfg_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WINIT = 3'd1,
    WLOAD = 3'd2,
    BINIT = 3'd3,
    BLOAD = 3'd4,
    RUN   = 3'd5,
    NEXT  = 3'd6
  } sched_state_e;

  // Weight beats per layer; 16 x 256 = 4096 still fits the 13-bit result.
  function automatic logic [BEAT_W-1:0] weight_beats(input layer_cfg_t cfg);
    return (BEAT_W'(cfg.od) + BEAT_W'(1)) * (BEAT_W'(cfg.fs) + BEAT_W'(1));
  endfunction

endpackage

// File: rtl/layer_cfg_ram.sv
// Layer descriptor table: one synchronous write port, one asynchronous read
// port. Deliberately not reset so descriptors survive an abort.
module layer_cfg_ram
  import tiny_dnn_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  layer_cfg_t       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output layer_cfg_t       rdata_o
);

  layer_cfg_t mem_q [MAX_LAYERS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_sched.sv
// Layer sequencer: walks each configured layer through weight load, bias load
// and run phases, gating only the stream handshake toward the accelerator.
module layer_sched
  import tiny_dnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  layer_cfg_t       cfg_data,
  input  logic             start,
  input  logic [IDX_W-1:0] nlayers,
  input  logic [NB_W-1:0]  nbatch,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             dst_valid,
  input  logic             dst_ready,
  output logic             run,
  output logic             wwrite,
  output logic             bwrite,
  output logic [SS_W-1:0]  ss,
  output logic [ID_W-1:0]  id,
  output logic [IS_W-1:0]  is,
  output logic [IH_W-1:0]  ih,
  output logic [IW_W-1:0]  iw,
  output logic [DS_W-1:0]  ds,
  output logic [OD_W-1:0]  od,
  output logic [OS_W-1:0]  os,
  output logic [OH_W-1:0]  oh,
  output logic [OW_W-1:0]  ow,
  output logic [FS_W-1:0]  fs,
  output logic [KH_W-1:0]  kh,
  output logic [KW_W-1:0]  kw,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] layer_idx
);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  layer_idx_q, layer_idx_d;
  logic [IDX_W-1:0]  nlayers_q, nlayers_d;
  logic [NB_W-1:0]   nbatch_q, nbatch_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DS_W-1:0]   dst_cnt_q, dst_cnt_d;
  logic [NB_W-1:0]   smp_cnt_q, smp_cnt_d;
  layer_cfg_t        geo_q, geo_d;
  logic              gate_q, gate_d;
  logic              wwrite_q, wwrite_d;
  logic              bwrite_q, bwrite_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cfg_wr;
  layer_cfg_t        cfg_rd;
  logic              s_fire;
  logic              d_fire;
  logic [BEAT_W-1:0] wt_beats;

  // Descriptor writes are only honoured while idle.
  assign cfg_wr = cfg_we && (state_q == IDLE);

  layer_cfg_ram u_cfg_ram (
    .clk     (clk),
    .we_i    (cfg_wr),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (layer_idx_d),
    .rdata_o (cfg_rd)
  );

  assign s_fire   = gate_q && s_valid && m_ready;
  assign d_fire   = (state_q == RUN) && dst_valid && dst_ready;
  assign wt_beats = weight_beats(geo_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      layer_idx_q <= '0;
      nlayers_q   <= '0;
      nbatch_q    <= '0;
      beat_cnt_q  <= '0;
      dst_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      geo_q       <= '0;
      gate_q      <= 1'b0;
      wwrite_q    <= 1'b0;
      bwrite_q    <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      nlayers_q   <= nlayers_d;
      nbatch_q    <= nbatch_d;
      beat_cnt_q  <= beat_cnt_d;
      dst_cnt_q   <= dst_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      geo_q       <= geo_d;
      gate_q      <= gate_d;
      wwrite_q    <= wwrite_d;
      bwrite_q    <= bwrite_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    nlayers_d   = nlayers_q;
    nbatch_d    = nbatch_q;
    beat_cnt_d  = beat_cnt_q;
    dst_cnt_d   = dst_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    geo_d       = geo_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nlayers_d   = nlayers;
          nbatch_d    = nbatch;
          layer_idx_d = '0;
          state_d     = WINIT;
        end
      end
      WINIT: state_d = WLOAD;
      WLOAD: begin
        if (s_fire) begin
          if (beat_cnt_q == wt_beats - BEAT_W'(1)) begin
            state_d = BINIT;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      BINIT: state_d = BLOAD;
      BLOAD: begin
        if (s_fire) begin
          if (beat_cnt_q == BEAT_W'(geo_q.od)) begin
            state_d = RUN;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      RUN: begin
        // A sample ends on its ds+1-th output beat; the layer ends after nbatch+1 samples.
        if (d_fire) begin
          if (dst_cnt_q == geo_q.ds) begin
            dst_cnt_d = '0;
            if (smp_cnt_q == nbatch_q) begin
              state_d = NEXT;
            end else begin
              smp_cnt_d = smp_cnt_q + NB_W'(1);
            end
          end else begin
            dst_cnt_d = dst_cnt_q + DS_W'(1);
          end
        end
      end
      NEXT: begin
        if (layer_idx_q < nlayers_q) begin
          layer_idx_d = layer_idx_q + IDX_W'(1);
          state_d     = WINIT;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      beat_cnt_d = '0;
      dst_cnt_d  = '0;
      smp_cnt_d  = '0;
    end

    // Latch the new layer's geometry on entry to WINIT; forward a same-cycle write.
    if ((state_d == WINIT) && (state_q != WINIT)) begin
      if (cfg_wr && (cfg_addr == layer_idx_d)) begin
        geo_d = cfg_data;
      end else begin
        geo_d = cfg_rd;
      end
    end

    wwrite_d = (state_d == WINIT) || (state_d == WLOAD);
    bwrite_d = (state_d == BINIT) || (state_d == BLOAD);
    run_d    = (state_d == RUN);
    gate_d   = (state_d == WLOAD) || (state_d == BLOAD) || (state_d == RUN);
    busy_d   = (state_d != IDLE);
  end

  assign m_valid   = gate_q && s_valid;
  assign s_ready   = gate_q && m_ready;
  assign run       = run_q;
  assign wwrite    = wwrite_q;
  assign bwrite    = bwrite_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign layer_idx = layer_idx_q;

  assign ss = geo_q.ss;
  assign id = geo_q.id;
  assign is = geo_q.is;
  assign ih = geo_q.ih;
  assign iw = geo_q.iw;
  assign ds = geo_q.ds;
  assign od = geo_q.od;
  assign os = geo_q.os;
  assign oh = geo_q.oh;
  assign ow = geo_q.ow;
  assign fs = geo_q.fs;
  assign kh = geo_q.kh;
  assign kw = geo_q.kw;

endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: each network run is expanded into an expected list of
// phases with beat budgets, and the DUT is checked against it cycle by cycle.
module tb_layer_sched;
  import tiny_dnn_pkg::*;

  localparam int M_WINIT = 0;
  localparam int M_WLOAD = 1;
  localparam int M_BINIT = 2;
  localparam int M_BLOAD = 3;
  localparam int M_RUN   = 4;
  localparam int M_GAP   = 5;
  localparam int M_DONE  = 6;
  localparam int LIMIT   = 6000;

  typedef struct {
    int mode;
    int layer;
    int need;
  } seg_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  layer_cfg_t       cfg_data;
  logic             start;
  logic [2:0]       nlayers;
  logic [7:0]       nbatch;
  logic             s_valid, s_ready, m_valid, m_ready;
  logic             dst_valid, dst_ready;
  logic             run, wwrite, bwrite, busy, done;
  logic [2:0]       layer_idx;
  logic [11:0]      ss, ds;
  logic [3:0]       id, od;
  logic [9:0]       is, os;
  logic [4:0]       ih, iw, oh, ow;
  logic [7:0]       fs;
  logic [2:0]       kh, kw;
  layer_cfg_t       geo_obs;

  layer_cfg_t desc_m [MAX_LAYERS];
  seg_t       sched [$];
  int         checks = 0;
  int         errors = 0;
  layer_cfg_t d;

  always #5 clk = ~clk;

  assign geo_obs = {ss, id, is, ih, iw, ds, od, os, oh, ow, fs, kh, kw};

  layer_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .nlayers(nlayers), .nbatch(nbatch),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .run(run), .wwrite(wwrite), .bwrite(bwrite),
    .ss(ss), .id(id), .is(is), .ih(ih), .iw(iw), .ds(ds), .od(od), .os(os),
    .oh(oh), .ow(ow), .fs(fs), .kh(kh), .kw(kw),
    .busy(busy), .done(done), .layer_idx(layer_idx)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic layer_cfg_t rand_desc();
    logic [95:0] r;
    layer_cfg_t  c;
    r    = {$urandom(), $urandom(), $urandom()};
    c    = r[85:0];
    c.od = 4'($urandom_range(0, 3));
    c.fs = 8'($urandom_range(0, 7));
    c.ds = 12'($urandom_range(0, 3));
    return c;
  endfunction

  task automatic write_desc(input int l, input layer_cfg_t c);
    cfg_we   = 1'b1;
    cfg_addr = 3'(l);
    cfg_data = c;
    desc_m[l] = c;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Each layer: addr init, weights, addr init, biases, samples, one idle gap.
  function automatic void build_sched(input int nl, input int nb);
    sched.delete();
    for (int l = 0; l <= nl; l++) begin
      sched.push_back(seg_t'{M_WINIT, l, 1});
      sched.push_back(seg_t'{M_WLOAD, l, (int'(desc_m[l].od) + 1) * (int'(desc_m[l].fs) + 1)});
      sched.push_back(seg_t'{M_BINIT, l, 1});
      sched.push_back(seg_t'{M_BLOAD, l, int'(desc_m[l].od) + 1});
      sched.push_back(seg_t'{M_RUN, l, (int'(desc_m[l].ds) + 1) * (nb + 1)});
      sched.push_back(seg_t'{M_GAP, l, 1});
    end
    sched.push_back(seg_t'{M_DONE, nl, 1});
  endfunction

  task automatic drive_hs(input int hs, input int cyc);
    dst_valid = ($urandom_range(0, 3) != 0);
    dst_ready = ($urandom_range(0, 3) != 0);
    case (hs)
      1: begin
        s_valid = 1'b1; m_ready = 1'b1; dst_valid = 1'b1; dst_ready = 1'b1;
      end
      2: begin
        s_valid = 1'b1; m_ready = cyc[0];
      end
      default: begin
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " busy"}, 128'(busy), 128'(0));
    chk({tag, " done"}, 128'(done), 128'(0));
    chk({tag, " run"}, 128'(run), 128'(0));
    chk({tag, " wwrite"}, 128'(wwrite), 128'(0));
    chk({tag, " bwrite"}, 128'(bwrite), 128'(0));
    chk({tag, " m_valid"}, 128'(m_valid), 128'(0));
    chk({tag, " s_ready"}, 128'(s_ready), 128'(0));
    chk({tag, " layer_idx"}, 128'(layer_idx), 128'(0));
    chk({tag, " geometry"}, 128'(geo_obs), 128'(0));
  endtask

  task automatic check_cycle(input seg_t seg);
    bit    wexp, bexp, rexp, open;
    string t;
    t    = $sformatf("L%0d ph%0d", seg.layer, seg.mode);
    wexp = (seg.mode == M_WINIT) || (seg.mode == M_WLOAD);
    bexp = (seg.mode == M_BINIT) || (seg.mode == M_BLOAD);
    rexp = (seg.mode == M_RUN);
    open = (seg.mode == M_WLOAD) || (seg.mode == M_BLOAD) || (seg.mode == M_RUN);
    chk({"wwrite ", t}, 128'(wwrite), 128'(wexp));
    chk({"bwrite ", t}, 128'(bwrite), 128'(bexp));
    chk({"run ", t}, 128'(run), 128'(rexp));
    chk({"done ", t}, 128'(done), 128'(seg.mode == M_DONE));
    chk({"busy ", t}, 128'(busy), 128'(seg.mode != M_DONE));
    chk({"m_valid ", t}, 128'(m_valid), 128'(open && s_valid));
    chk({"s_ready ", t}, 128'(s_ready), 128'(open && m_ready));
    if (seg.mode != M_DONE) begin
      chk({"layer_idx ", t}, 128'(layer_idx), 128'(seg.layer));
      chk({"geometry ", t}, 128'(geo_obs), 128'(desc_m[seg.layer]));
    end
  endtask

  task automatic run_net(input int nl, input int nb, input int hs, input bit disturb,
                         input bit abort_bload);
    int   si = 0;
    int   cnt = 0;
    int   cyc = 0;
    bit   dist_done = 1'b0;
    seg_t seg;
    build_sched(nl, nb);
    start   = 1'b1;
    nlayers = 3'(nl);
    nbatch  = 8'(nb);
    @(posedge clk); #1;
    while (si < sched.size() && cyc <= LIMIT) begin
      start   = 1'b0;
      cfg_we  = 1'b0;
      nlayers = 3'(nl);
      drive_hs(hs, cyc);
      if (disturb && !dist_done && sched[si].mode == M_RUN) begin
        dist_done = 1'b1;
        start     = 1'b1;
        nlayers   = 3'd7;
        cfg_we    = 1'b1;
        cfg_addr  = 3'(sched[si].layer);
        cfg_data  = ~desc_m[sched[si].layer];
      end
      @(negedge clk);
      seg = sched[si];
      check_cycle(seg);
      if (abort_bload && seg.mode == M_BLOAD) begin
        s_valid = 1'b1;
        m_ready = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (seg.mode == M_WLOAD || seg.mode == M_BLOAD) begin
        if (s_valid && s_ready) cnt++;
      end else if (seg.mode == M_RUN) begin
        if (dst_valid && dst_ready) cnt++;
      end else begin
        cnt++;
      end
      if (cnt >= seg.need) begin
        si++;
        cnt = 0;
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk("schedule complete", 128'(si), 128'(sched.size()));
    start   = 1'b0;
    cfg_we  = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("post done", 128'(done), 128'(0));
    chk("post busy", 128'(busy), 128'(0));
    chk("post s_ready", 128'(s_ready), 128'(0));
    chk("post m_valid", 128'(m_valid), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    nlayers = '0; nbatch = '0; s_valid = 1'b1; m_ready = 1'b1;
    dst_valid = 1'b0; dst_ready = 1'b0;
    #12 check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int l = 0; l < int'(MAX_LAYERS); l++) write_desc(l, rand_desc());

    // Single layer: 8 weight beats, 2 bias beats, 2 output beats.
    d = desc_m[0];
    d.od = 4'd1; d.fs = 8'd3; d.ss = 12'd3; d.ds = 12'd1;
    write_desc(0, d);
    run_net(0, 0, 1, 1'b0, 1'b0);

    // Weight phase under m_ready toggling every other cycle.
    run_net(0, 0, 2, 1'b0, 1'b0);

    // Three layers with distinct descriptors.
    run_net(2, 0, 0, 1'b0, 1'b0);

    // Four samples in one layer.
    run_net(0, 3, 0, 1'b0, 1'b0);

    // Descriptor write coincident with start must reach layer 0.
    d = rand_desc();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = d; desc_m[0] = d;
    run_net(1, 1, 0, 1'b0, 1'b0);

    // start/cfg_we during RUN are ignored; rerun proves the table is intact.
    run_net(0, 1, 0, 1'b1, 1'b0);
    run_net(0, 0, 0, 1'b0, 1'b0);

    // Abort in bias load, no done afterwards, then restart from layer 0.
    run_net(1, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after abort done", 128'(done), 128'(0));
      chk("after abort busy", 128'(busy), 128'(0));
      @(posedge clk); #1;
    end
    run_net(1, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_net(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
